rsa_exp_datapath: RTL and testbench

//   Responder end of the exponentiation control interface: consumes rst_mmm/ld_a/ld_r/lock1/lock2/sel1/sel2/eoc

---
 rtl/rsa_pkg.sv | 16 +
 rtl/rsa_exp_datapath_if.sv | 28 ++
 rtl/mmm_serial.sv | 61 ++++++
 rtl/rsa_exp_datapath.sv | 82 ++++++++
 tb/tb_rsa_exp_datapath.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// Shared operand-select encodings and Montgomery iteration count for the
// exponentiation datapath.
package rsa_pkg;

  localparam logic [1:0] SEL1_INIT = 2'b00;
  localparam logic [1:0] SEL1_MUL  = 2'b01;
  localparam logic [1:0] SEL1_OUT  = 2'b10;
  localparam logic       SEL2_INIT = 1'b0;
  localparam logic       SEL2_SQR  = 1'b1;

  // R = 2^(WIDTH+2) keeps the Montgomery output below 2M for operands below 2M
  function automatic int iter_f(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/rsa_exp_datapath_if.sv
// Control/data bundle between the exponentiation controller and the datapath.
interface rsa_exp_datapath_if #(parameter int WIDTH = 8);

  logic             rst_mmm;
  logic             ld_a;
  logic             ld_r;
  logic             lock1;
  logic             lock2;
  logic [1:0]       sel1;
  logic             sel2;
  logic             eoc;
  logic [WIDTH-1:0] msg;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] r2modm;
  logic [WIDTH-1:0] result;
  logic             done;

  modport master (
    output rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, eoc, msg, modulus, r2modm,
    input  result, done
  );

  modport slave (
    input  rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, eoc, msg, modulus, r2modm,
    output result, done
  );

endinterface

// File: rtl/mmm_serial.sv
// Bit-serial Montgomery multiplier: s = a*b*2^-(WIDTH+2) mod m, result < 2m,
// one operand bit consumed per cycle after start.
module mmm_serial
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH:0]   b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH+1:0] s,
  output logic             ready
);

  localparam int ITER = iter_f(WIDTH);
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] ITER_C = CW'(ITER);

  logic [WIDTH:0]   a_q, b_q;
  logic [WIDTH+1:0] s_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH+2:0] t, u;
  logic             q;

  // One extra bit over S so t + q*M (< 6M) never overflows
  always_comb begin
    t = {1'b0, s_q} + (a_q[0] ? {2'b00, b_q} : '0);
    q = t[0];
    u = t + (q ? {3'b000, m} : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      cnt_q <= '0;
    end else begin
      if (start) begin
        a_q <= a;
        b_q <= b;
      end
      if (clr || start) begin
        s_q   <= '0;
        cnt_q <= '0;
      end else if (cnt_q != ITER_C) begin
        s_q   <= u[WIDTH+2:1];
        a_q   <= a_q >> 1;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign s     = s_q;
  assign ready = (cnt_q == ITER_C);

endmodule

// File: rtl/rsa_exp_datapath.sv
// Right-to-left Montgomery exponentiation datapath: X/P registers, two serial
// multipliers, and the final reduction that produces result with a done pulse.
module rsa_exp_datapath
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  rsa_exp_datapath_if.slave   bus
);

  localparam int XW = WIDTH + 1;

  logic [XW-1:0]    x_q, x_d, p_q, p_d;
  logic [XW-1:0]    a1, b1, a2, b2;
  logic [WIDTH+1:0] s1, s2;
  logic [WIDTH-1:0] res_q, res_d;
  logic             done_q;
  logic             rdy1, rdy2;
  logic             unused_rdy;

  always_comb begin
    a1 = x_q;
    b1 = XW'(1);
    case (bus.sel1)
      SEL1_INIT: begin a1 = {1'b0, bus.r2modm}; b1 = XW'(1); end
      SEL1_MUL:  begin a1 = x_q;                b1 = p_q;    end
      default:   begin a1 = x_q;                b1 = XW'(1); end
    endcase
    if (bus.sel2 == SEL2_SQR) begin
      a2 = p_q;
      b2 = p_q;
    end else begin
      a2 = {1'b0, bus.msg};
      b2 = {1'b0, bus.r2modm};
    end
  end

  mmm_serial #(.WIDTH(WIDTH)) u_mmm1 (
    .clk(clk), .rst(rst), .clr(~bus.rst_mmm), .start(bus.ld_a),
    .a(a1), .b(b1), .m(bus.modulus), .s(s1), .ready(rdy1)
  );

  mmm_serial #(.WIDTH(WIDTH)) u_mmm2 (
    .clk(clk), .rst(rst), .clr(~bus.rst_mmm), .start(bus.ld_a),
    .a(a2), .b(b2), .m(bus.modulus), .s(s2), .ready(rdy2)
  );

  // Controller owns iteration timing; ready is kept only for debug visibility
  assign unused_rdy = &{1'b0, rdy1, rdy2};

  // x_d doubles as the X value seen by eoc, so a same-edge capture is corrected too
  always_comb begin
    x_d   = x_q;
    p_d   = p_q;
    res_d = res_q;
    if (bus.ld_r && bus.lock1) x_d = XW'(s1);
    if (bus.ld_r && bus.lock2) p_d = XW'(s2);
    if (bus.eoc)
      res_d = (x_d >= {1'b0, bus.modulus}) ? WIDTH'(x_d - {1'b0, bus.modulus})
                                           : WIDTH'(x_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      p_q    <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      p_q    <= p_d;
      res_q  <= res_d;
      done_q <= bus.eoc;
    end
  end

  assign bus.result = res_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_rsa_exp_datapath.sv
// Directed checks of the exponentiation datapath with M=187, R mod M=89, r2modm=67.
module tb_rsa_exp_datapath;
  import rsa_pkg::*;

  localparam int W    = 8;
  localparam int ITER = iter_f(W);
  localparam int M    = 187;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rsa_exp_datapath_if #(.WIDTH(W)) bus ();

  rsa_exp_datapath #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ctrl();
    bus.ld_a  = 1'b0;
    bus.ld_r  = 1'b0;
    bus.lock1 = 1'b0;
    bus.lock2 = 1'b0;
    bus.eoc   = 1'b0;
  endtask

  // ld_a, ITER iteration cycles, then ld_r (optionally with eoc)
  task automatic slot(input logic [1:0] s1, input logic s2, input logic l1,
                      input logic l2, input logic e);
    bus.sel1 = s1;
    bus.sel2 = s2;
    bus.ld_a = 1'b1;
    cyc();
    bus.ld_a = 1'b0;
    repeat (ITER) cyc();
    bus.ld_r  = 1'b1;
    bus.lock1 = l1;
    bus.lock2 = l2;
    bus.eoc   = e;
    cyc();
    clr_ctrl();
  endtask

  task automatic run_exp(input logic [W-1:0] m, input logic [3:0] e, input logic eoc_final);
    bus.msg = m;
    slot(SEL1_INIT, SEL2_INIT, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) slot(SEL1_MUL, SEL2_SQR, e[i], 1'b1, 1'b0);
    slot(SEL1_OUT, SEL2_INIT, 1'b1, 1'b0, eoc_final);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ld_a = 1'b1; bus.ld_r = 1'b1; bus.lock1 = 1'b1; bus.lock2 = 1'b1; bus.eoc = 1'b1;
    cyc();
    cyc();
    n_chk++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
    n_chk++;
    if (bus.result !== 8'd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", bus.result); end
    n_chk++;
    if (dut.x_q !== 9'd0 || dut.p_q !== 9'd0)
      begin n_fail++; $display("FAIL reset_xp: got X=%0d P=%0d expected 0 0", dut.x_q, dut.p_q); end
    rst = 1'b0;
    clr_ctrl();
    cyc();
  endtask

  task automatic test_single_mmm();
    int xv;
    slot(SEL1_INIT, SEL2_INIT, 1'b1, 1'b0, 1'b0);
    xv = int'(dut.x_q);
    n_chk++;
    if (xv % M != 89) begin n_fail++; $display("FAIL single_x_mod: got %0d expected 89", xv % M); end
    n_chk++;
    if (xv >= 2 * M) begin n_fail++; $display("FAIL single_x_range: got %0d expected < 374", xv); end
    n_chk++;
    if (dut.p_q !== 9'd0) begin n_fail++; $display("FAIL single_p_locked: got %0d expected 0", dut.p_q); end
  endtask

  task automatic test_exp3();
    run_exp(8'd5, 4'b0011, 1'b1);
    n_chk++;
    if (bus.done !== 1'b1) begin n_fail++; $display("FAIL exp3_done: got %0b expected 1", bus.done); end
    n_chk++;
    if (bus.result !== 8'd125) begin n_fail++; $display("FAIL exp3_result: got %0d expected 125", bus.result); end
    cyc();
    n_chk++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL exp3_done_pulse: got %0b expected 0", bus.done); end
  endtask

  task automatic test_rst_midloop();
    bus.msg = 8'd5;
    slot(SEL1_INIT, SEL2_INIT, 1'b1, 1'b1, 1'b0);
    bus.sel1 = SEL1_MUL;
    bus.sel2 = SEL2_SQR;
    bus.ld_a = 1'b1;
    cyc();
    bus.ld_a = 1'b0;
    repeat (4) cyc();
    rst = 1'b1;
    bus.eoc = 1'b1;
    cyc();
    n_chk++;
    if (dut.x_q !== 9'd0 || dut.p_q !== 9'd0 || dut.u_mmm1.s_q !== 10'd0)
      begin n_fail++; $display("FAIL midrst_regs: got X=%0d P=%0d S1=%0d expected 0 0 0", dut.x_q, dut.p_q, dut.u_mmm1.s_q); end
    n_chk++;
    if (bus.result !== 8'd0 || bus.done !== 1'b0)
      begin n_fail++; $display("FAIL midrst_out: got result=%0d done=%0b expected 0 0", bus.result, bus.done); end
    rst = 1'b0;
    clr_ctrl();
    run_exp(8'd5, 4'b0011, 1'b1);
    n_chk++;
    if (bus.result !== 8'd125 || bus.done !== 1'b1)
      begin n_fail++; $display("FAIL midrst_rerun: got result=%0d done=%0b expected 125 1", bus.result, bus.done); end
    cyc();
  endtask

  task automatic test_exp0_eoc_hold();
    run_exp(8'd5, 4'b0000, 1'b0);
    n_chk++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL exp0_no_eoc: got done=%0b expected 0", bus.done); end
    bus.eoc = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_chk++;
      if (bus.done !== 1'b1 || bus.result !== 8'd1)
        begin n_fail++; $display("FAIL exp0_hold%0d: got result=%0d done=%0b expected 1 1", i, bus.result, bus.done); end
    end
    bus.eoc = 1'b0;
    cyc();
    n_chk++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL exp0_done_fall: got %0b expected 0", bus.done); end
  endtask

  task automatic test_rst_mmm_hold();
    n_chk++;
    if (dut.x_q === 9'd0) begin n_fail++; $display("FAIL mmmclr_precond: got X=0 expected nonzero"); end
    bus.rst_mmm = 1'b0;
    slot(SEL1_INIT, SEL2_INIT, 1'b1, 1'b1, 1'b0);
    n_chk++;
    if (dut.x_q !== 9'd0 || dut.p_q !== 9'd0)
      begin n_fail++; $display("FAIL mmmclr_xp: got X=%0d P=%0d expected 0 0", dut.x_q, dut.p_q); end
    bus.rst_mmm = 1'b1;
  endtask

  // Next ld_a rides on the capturing ld_r edge: operands must be the old X=P=0
  task automatic test_back_to_back();
    int xv, pv;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.msg  = 8'd5;
    bus.sel1 = SEL1_INIT;
    bus.sel2 = SEL2_INIT;
    bus.ld_a = 1'b1;
    cyc();
    bus.ld_a = 1'b0;
    repeat (ITER) cyc();
    bus.ld_r = 1'b1; bus.lock1 = 1'b1; bus.lock2 = 1'b1;
    bus.ld_a = 1'b1; bus.sel1 = SEL1_MUL; bus.sel2 = SEL2_SQR;
    cyc();
    clr_ctrl();
    xv = int'(dut.x_q);
    pv = int'(dut.p_q);
    n_chk++;
    if (xv % M != 89 || pv % M != 71)
      begin n_fail++; $display("FAIL b2b_capture: got X%%M=%0d P%%M=%0d expected 89 71", xv % M, pv % M); end
    repeat (ITER) cyc();
    bus.ld_r = 1'b1; bus.lock1 = 1'b1; bus.lock2 = 1'b1;
    cyc();
    clr_ctrl();
    n_chk++;
    if (dut.x_q !== 9'd0 || dut.p_q !== 9'd0)
      begin n_fail++; $display("FAIL b2b_old_operands: got X=%0d P=%0d expected 0 0", dut.x_q, dut.p_q); end
  endtask

  initial begin
    rst         = 1'b1;
    bus.rst_mmm = 1'b1;
    bus.sel1    = SEL1_INIT;
    bus.sel2    = SEL2_INIT;
    bus.msg     = 8'd5;
    bus.modulus = 8'd187;
    bus.r2modm  = 8'd67;
    clr_ctrl();
    #2;
    test_reset();
    test_single_mmm();
    test_exp3();
    test_rst_midloop();
    test_exp0_eoc_hold();
    test_rst_mmm_hold();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule
